// File: rtl/vga_pkg.sv
// Shared VGA pipeline widths and timing constants.
// Pixel format is 4:4:4 RGB.
package vga_pkg;

  localparam int DEF_CNT_W = 11;
  localparam int DEF_RGB_W = 12;

  localparam int H_ACTIVE  = 800;
  localparam int H_TOTAL   = 1056;
  localparam int V_ACTIVE  = 600;
  localparam int V_TOTAL   = 628;

endpackage

// File: rtl/sprite_rom_mem.sv
// Sprite image ROM: one registered read per clock.
// Contents are preloaded by the surrounding environment.
module sprite_rom_mem #(
  parameter int    ADDR_W   = 12,
  parameter int    DATA_W   = 12,
  parameter string ROM_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] rom [2**ADDR_W];

  always_ff @(posedge clk) begin
    data_o <= rom[addr_i];
  end

endmodule

// File: rtl/sprite_rom_draw.sv
// Sprite overlay for the VGA stream: ROM image at a per-frame origin,
// colour-key transparency and horizontal mirroring, fixed 2-cycle latency.
module sprite_rom_draw
  import vga_pkg::*;
#(
  parameter int    IMG_W    = 48,
  parameter int    IMG_H    = 64,
  parameter int    ADDR_X_W = 6,
  parameter int    ADDR_Y_W = 6,
  parameter int    RGB_W    = DEF_RGB_W,
  parameter int    CNT_W    = DEF_CNT_W,
  parameter logic [RGB_W-1:0] KEY_RGB = RGB_W'(12'hF0F),
  parameter string ROM_FILE = "../../rtl/sprite/sprite.data"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic [CNT_W:0]   xpos,
  input  logic [CNT_W:0]   ypos,
  input  logic             flip_h,
  input  logic             enable,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int DW = CNT_W + 2;
  localparam int AW = ADDR_X_W + ADDR_Y_W;
  localparam int SW = 2 * CNT_W + 4 + RGB_W;

  logic             frame_start;
  logic [CNT_W:0]   xpos_q, ypos_q;
  logic [CNT_W:0]   xpos_c, ypos_c;
  logic             flip_q, en_q;
  logic             flip_c, en_c;
  logic [DW-1:0]    rx, ry;
  logic [ADDR_X_W-1:0] ax;
  logic             hit_d;
  logic [AW-1:0]    addr_d, addr_q;
  logic [SW-1:0]    s1_q, s2_q;
  logic             hit1_q, hit2_q;
  logic [RGB_W-1:0] pix;
  logic [RGB_W-1:0] rgb_bg;

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos_q <= '0;
      ypos_q <= '0;
      flip_q <= 1'b0;
      en_q   <= 1'b0;
    end else if (frame_start) begin
      xpos_q <= xpos;
      ypos_q <= ypos;
      flip_q <= flip_h;
      en_q   <= enable;
    end
  end

  // The latch pixel itself already belongs to the new frame.
  always_comb begin
    xpos_c = frame_start ? xpos   : xpos_q;
    ypos_c = frame_start ? ypos   : ypos_q;
    flip_c = frame_start ? flip_h : flip_q;
    en_c   = frame_start ? enable : en_q;
    rx = {2'b00, hcount_in} - {xpos_c[CNT_W], xpos_c};
    ry = {2'b00, vcount_in} - {ypos_c[CNT_W], ypos_c};
    // Negative offsets wrap to huge unsigned values and miss.
    hit_d = en_c && (rx < DW'(IMG_W)) && (ry < DW'(IMG_H));
    ax = flip_c ? ADDR_X_W'(IMG_W - 1) - rx[ADDR_X_W-1:0]
                : rx[ADDR_X_W-1:0];
    addr_d = {ry[ADDR_Y_W-1:0], ax};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      addr_q <= '0;
    end else begin
      s1_q   <= {hcount_in, vcount_in, hsync_in, vsync_in,
                 hblnk_in, vblnk_in, rgb_in};
      s2_q   <= s1_q;
      hit1_q <= hit_d;
      hit2_q <= hit1_q;
      addr_q <= addr_d;
    end
  end

  sprite_rom_mem #(
    .ADDR_W   (AW),
    .DATA_W   (RGB_W),
    .ROM_FILE (ROM_FILE)
  ) u_rom (
    .clk    (clk),
    .addr_i (addr_q),
    .data_o (pix)
  );

  assign {hcount_out, vcount_out, hsync_out, vsync_out,
          hblnk_out, vblnk_out, rgb_bg} = s2_q;

  always_comb begin
    rgb_out = rgb_bg;
    if (hblnk_out || vblnk_out)
      rgb_out = '0;
    else if (hit2_q && (pix != KEY_RGB))
      rgb_out = pix;
  end

endmodule

// File: tb/tb_sprite_rom_draw.sv
// Bench for sprite_rom_draw: directed table, corner sequences and
// random traffic against a pixel-level reference model.
module tb_sprite_rom_draw;

  localparam int CW = 11;
  localparam int RW = 12;
  localparam int XW = CW + 1;
  localparam int IW = 48;
  localparam int IH = 64;
  localparam logic [RW-1:0] KEY = 12'hF0F;

  localparam int BG = 0;
  localparam int RM = 1;
  localparam int ZR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] hcount_in = '0, vcount_in = '0;
  logic          hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
  logic [RW-1:0] rgb_in = '0;
  logic [CW:0]   xpos = '0, ypos = '0;
  logic          flip_h = 0, enable = 0;
  logic [CW-1:0] hcount_out, vcount_out;
  logic          hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [RW-1:0] rgb_out;

  always #5 clk = ~clk;

  sprite_rom_draw #(.ROM_FILE("")) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .flip_h(flip_h), .enable(enable),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic hs, vs, hb, vb;
    logic [RW-1:0] rgb;
  } out_t;

  typedef struct {
    string nm;
    int h, v, hb, vb, rgb, x, y, f, e, src, addr;
  } vec_t;

  logic [RW-1:0] rom_m [4096];
  out_t expq[$];
  int mx, my, mf, me;
  int checks = 0;
  int failures = 0;
  vec_t tbl[17];

  function automatic out_t cur_out();
    return {hcount_out, vcount_out, hsync_out, vsync_out,
            hblnk_out, vblnk_out, rgb_out};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Applies one pixel, predicts its output and checks the one from 2 clk ago.
  task automatic cycle(input int h, v, hs, vs, hb, vb, rgb,
                       input int x, y, f, e);
    out_t ex, got;
    int rx, ry, col;
    bit hit;
    logic [RW-1:0] pix;
    hcount_in = CW'(h);
    vcount_in = CW'(v);
    hsync_in = hs[0];
    vsync_in = vs[0];
    hblnk_in = hb[0];
    vblnk_in = vb[0];
    rgb_in = RW'(rgb);
    xpos = XW'(x);
    ypos = XW'(y);
    flip_h = f[0];
    enable = e[0];
    if (h == 0 && v == 0) begin
      mx = x; my = y; mf = f; me = e;
    end
    rx = h - mx;
    ry = v - my;
    hit = (me != 0) && rx >= 0 && rx < IW && ry >= 0 && ry < IH;
    pix = '0;
    if (hit) begin
      col = (mf != 0) ? IW - 1 - rx : rx;
      pix = rom_m[ry * 64 + col];
    end
    ex.h = CW'(h);
    ex.v = CW'(v);
    ex.hs = hs[0];
    ex.vs = vs[0];
    ex.hb = hb[0];
    ex.vb = vb[0];
    if (hb != 0 || vb != 0) ex.rgb = '0;
    else if (hit && pix != KEY) ex.rgb = pix;
    else ex.rgb = RW'(rgb);
    expq.push_back(ex);
    @(negedge clk);
    if (expq.size() == 2) begin
      ex = expq.pop_front();
      got = cur_out();
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL model h=%0d v=%0d act=%h exp=%h",
                 ex.h, ex.v, got, ex);
      end
    end
  endtask

  task automatic latch(input int x, y, f, e);
    cycle(0, 0, 0, 0, 1, 0, 0, x, y, f, e);
  endtask

  task automatic probe(input int h, v, hb, vb, rgb, x, y, f, e);
    cycle(h, v, 0, 0, hb, vb, rgb, x, y, f, e);
    cycle(600, 600, 0, 0, 0, 0, 0, x, y, f, e);
  endtask

  task automatic release_rst();
    rst = 1'b0;
    expq.delete();
    expq.push_back('0);
    mx = 0; my = 0; mf = 0; me = 0;
  endtask

  initial begin
    tbl[0]  = '{"latency",    100,   5, 0, 0, 'h123,  0,   0, 0, 0, BG, 0};
    tbl[1]  = '{"top_left",   200, 100, 0, 0, 'h111, 200, 100, 0, 1, RM, 0};
    tbl[2]  = '{"bot_right",  247, 163, 0, 0, 'h222, 200, 100, 0, 1, RM, 63*64+47};
    tbl[3]  = '{"right_miss", 248, 100, 0, 0, 'h333, 200, 100, 0, 1, BG, 0};
    tbl[4]  = '{"left_miss",  199, 100, 0, 0, 'h444, 200, 100, 0, 1, BG, 0};
    tbl[5]  = '{"bot_miss",   200, 164, 0, 0, 'h555, 200, 100, 0, 1, BG, 0};
    tbl[6]  = '{"top_miss",   200,  99, 0, 0, 'h666, 200, 100, 0, 1, BG, 0};
    tbl[7]  = '{"flip_left",  200, 100, 0, 0, 'h777, 200, 100, 1, 1, RM, 47};
    tbl[8]  = '{"flip_right", 247, 100, 0, 0, 'h788, 200, 100, 1, 1, RM, 0};
    tbl[9]  = '{"clip_left",    0, 120, 0, 0, 'h199, -10, 100, 0, 1, RM, 20*64+10};
    tbl[10] = '{"clip_edge",   37, 100, 0, 0, 'h2AA, -10, 100, 0, 1, RM, 47};
    tbl[11] = '{"clip_miss",   38, 100, 0, 0, 'h3BB, -10, 100, 0, 1, BG, 0};
    tbl[12] = '{"clip_top",   210,   0, 0, 0, 'h4CC, 200,  -5, 0, 1, RM, 5*64+10};
    tbl[13] = '{"far_right", 2047, 100, 0, 0, 'h5DD, 2000, 100, 0, 1, RM, 47};
    tbl[14] = '{"offscreen",  100, 100, 0, 0, 'h6EE, -100, 100, 0, 1, BG, 0};
    tbl[15] = '{"hblank",     200, 100, 1, 0, 'h7FF, 200, 100, 0, 1, ZR, 0};
    tbl[16] = '{"vblank",     210, 110, 0, 1, 'h801, 200, 100, 0, 1, ZR, 0};

    for (int i = 0; i < 4096; i++) begin
      rom_m[i] = RW'($urandom);
      if (i % 7 == 3) rom_m[i] = KEY;
      else if (rom_m[i] == KEY) rom_m[i] = 12'h0F0;
      dut.u_rom.rom[i] = rom_m[i];
    end

    repeat (3) @(negedge clk);
    chk("reset_state", 64'(cur_out()), 64'd0);
    release_rst();

    for (int i = 0; i < 17; i++) begin
      logic [RW-1:0] ex;
      latch(tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].e);
      probe(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].rgb,
            tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].e);
      if (tbl[i].src == ZR) ex = '0;
      else if (tbl[i].src == RM && rom_m[tbl[i].addr] != KEY)
        ex = rom_m[tbl[i].addr];
      else ex = RW'(tbl[i].rgb);
      chk({tbl[i].nm, "_rgb"}, 64'(rgb_out), 64'(ex));
      chk({tbl[i].nm, "_hcnt"}, 64'(hcount_out), 64'(tbl[i].h));
    end

    // Origin changes mid-frame must wait for the next (0,0).
    latch(200, 100, 0, 1);
    probe(200, 100, 0, 0, 'h0AA, 300, 100, 0, 1);
    chk("mid_frame_hold", 64'(rgb_out), 64'(rom_m[0]));
    probe(300, 100, 0, 0, 'h0BB, 300, 100, 0, 1);
    chk("mid_frame_old", 64'(rgb_out), 64'h0BB);
    latch(300, 100, 0, 1);
    probe(300, 100, 0, 0, 'h0CC, 300, 100, 0, 1);
    chk("next_frame", 64'(rgb_out), 64'(rom_m[0]));

    rom_m[0] = KEY;
    dut.u_rom.rom[0] = KEY;
    latch(200, 100, 0, 1);
    probe(200, 100, 0, 0, 'hABC, 200, 100, 0, 1);
    chk("key_transp", 64'(rgb_out), 64'hABC);
    rom_m[0] = 12'h5C3;
    dut.u_rom.rom[0] = 12'h5C3;

    for (int n = 0; n < 3000; n++) begin
      int h, v, x, y;
      if (n == 1500) begin
        latch(200, 100, 0, 1);
        probe(205, 105, 0, 0, 'h111, 200, 100, 0, 1);
        rst = 1'b1;
        #1;
        chk("reset_async", 64'(cur_out()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        release_rst();
        probe(200, 100, 0, 0, 'h5A5, 200, 100, 0, 1);
        chk("post_reset_hidden", 64'(rgb_out), 64'h5A5);
      end
      if ($urandom_range(0, 199) == 0) begin
        h = 0; v = 0;
      end else begin
        h = $urandom_range(0, 420);
        v = $urandom_range(0, 260);
      end
      x = int'($urandom_range(0, 420)) - 60;
      y = int'($urandom_range(0, 330)) - 70;
      cycle(h, v, $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            $urandom_range(0, 4095), x, y,
            $urandom_range(0, 1),
            ($urandom_range(0, 7) != 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
